// File: rtl/mcs_io_bus_ctrl_if.sv
// MicroBlaze MCS IO-bus signal bundle: the MCS is the master, the bus controller the slave.
interface mcs_io_bus_ctrl_if;
   logic [31:0] IO_Address;
   logic        IO_Addr_Strobe;
   logic        IO_Read_Strobe;
   logic        IO_Write_Strobe;
   logic [3:0]  IO_Byte_Enable;
   logic [31:0] IO_Write_Data;
   logic [31:0] IO_Read_Data;
   logic        IO_Ready;

   modport master (
      output IO_Address, IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe,
             IO_Byte_Enable, IO_Write_Data,
      input  IO_Read_Data, IO_Ready
   );

   modport slave (
      input  IO_Address, IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe,
             IO_Byte_Enable, IO_Write_Data,
      output IO_Read_Data, IO_Ready
   );
endinterface

// File: rtl/mcs_io_bus_ctrl.sv
// Sequences MCS IO-bus accesses onto NSLV peripheral slaves with strobe/ACK handshake
// and a timeout watchdog so every MCS access completes.
module mcs_io_bus_ctrl #(
   parameter int          NSLV      = 4,
   parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
   parameter int          SLV_AW    = 8,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] TO_DATA   = 32'hFFFF_FFFF
) (
   input  logic                 CLK,
   input  logic                 nRST,
   mcs_io_bus_ctrl_if.slave     io,
   output logic [SLV_AW-1:0]    SL_ADDR,
   output logic [31:0]          SL_WDATA,
   output logic [3:0]           SL_BE,
   output logic [NSLV-1:0]      SL_RD,
   output logic [NSLV-1:0]      SL_WR,
   input  logic [32*NSLV-1:0]   SL_RDATA,
   input  logic [NSLV-1:0]      SL_ACK,
   output logic                 ERR,
   output logic [31:0]          ERR_ADDR
);

   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_ISSUE = 2'd1;
   localparam logic [1:0]  ST_WAIT  = 2'd2;
   localparam logic [1:0]  ST_DONE  = 2'd3;
   localparam int          TAG_LSB  = SLV_AW + 3;
   localparam logic [15:0] TO_LIMIT = TIMEOUT[15:0];
   localparam logic [3:0]  NSLV_CNT = NSLV[3:0];

   logic [1:0]      state_reg;
   logic [15:0]     cnt_reg;
   logic            is_wr_reg;
   logic [NSLV-1:0] sel_reg;
   logic [31:0]     addr_reg;
   logic [31:0]     rdata_reg;
   logic            err_reg;
   logic [31:0]     err_addr_reg;
   logic [NSLV-1:0] rd_stb_reg;
   logic [NSLV-1:0] wr_stb_reg;

   logic            capture;
   logic [2:0]      dec_idx;
   logic            base_hit;
   logic            mapped;
   logic [NSLV-1:0] dec_onehot;
   logic            ack;
   logic [31:0]     slice_masked [NSLV];
   logic [31:0]     rdata_sel;

   assign capture  = (state_reg == ST_IDLE) && io.IO_Addr_Strobe &&
                     (io.IO_Read_Strobe || io.IO_Write_Strobe);
   assign dec_idx  = io.IO_Address[SLV_AW+2:SLV_AW];
   assign base_hit = (io.IO_Address[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
   assign mapped   = base_hit && ({1'b0, dec_idx} < NSLV_CNT);

   // ACKs from slaves other than the captured one are masked off here.
   assign ack = |(SL_ACK & sel_reg);

   generate
      for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
         assign dec_onehot[gi]   = (dec_idx == 3'(gi));
         assign slice_masked[gi] = SL_RDATA[32*gi +: 32] & {32{sel_reg[gi]}};
      end
   endgenerate

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < NSLV; i++) rdata_sel = rdata_sel | slice_masked[i];
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         is_wr_reg    <= 1'b0;
         sel_reg      <= '0;
         addr_reg     <= '0;
         rdata_reg    <= '0;
         err_reg      <= 1'b0;
         err_addr_reg <= '0;
         rd_stb_reg   <= '0;
         wr_stb_reg   <= '0;
         SL_ADDR      <= '0;
         SL_WDATA     <= '0;
         SL_BE        <= '0;
      end else begin
         rd_stb_reg <= '0;
         wr_stb_reg <= '0;
         err_reg    <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (capture) begin
                  addr_reg  <= io.IO_Address;
                  SL_ADDR   <= io.IO_Address[SLV_AW-1:0];
                  SL_WDATA  <= io.IO_Write_Data;
                  SL_BE     <= io.IO_Byte_Enable;
                  is_wr_reg <= io.IO_Write_Strobe;
                  cnt_reg   <= '0;
                  if (mapped) begin
                     sel_reg   <= dec_onehot;
                     state_reg <= ST_ISSUE;
                     if (io.IO_Write_Strobe) wr_stb_reg <= dec_onehot;
                     else                    rd_stb_reg <= dec_onehot;
                  end else begin
                     // Unmapped: complete immediately, writes are dropped.
                     sel_reg      <= '0;
                     state_reg    <= ST_DONE;
                     err_reg      <= 1'b1;
                     err_addr_reg <= io.IO_Address;
                     if (!io.IO_Write_Strobe) rdata_reg <= TO_DATA;
                  end
               end
            end
            ST_ISSUE: begin
               if (ack) begin
                  if (!is_wr_reg) rdata_reg <= rdata_sel;
                  state_reg <= ST_DONE;
               end else begin
                  cnt_reg   <= 16'd1;
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // ACK takes priority over a timeout landing in the same cycle.
               if (ack) begin
                  if (!is_wr_reg) rdata_reg <= rdata_sel;
                  state_reg <= ST_DONE;
               end else if (cnt_reg == TO_LIMIT) begin
                  if (!is_wr_reg) rdata_reg <= TO_DATA;
                  err_reg      <= 1'b1;
                  err_addr_reg <= addr_reg;
                  state_reg    <= ST_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign io.IO_Read_Data = rdata_reg;
   assign io.IO_Ready     = (state_reg == ST_DONE);
   assign SL_RD           = rd_stb_reg;
   assign SL_WR           = wr_stb_reg;
   assign ERR             = err_reg;
   assign ERR_ADDR        = err_addr_reg;

endmodule

// File: tb/tb_mcs_io_bus_ctrl.sv
// Directed testbench for mcs_io_bus_ctrl: reads, writes, unmapped access, timeout,
// ACK-at-timeout, wrong-slave ACK and reset during a wait.
module tb_mcs_io_bus_ctrl;
   logic          CLK;
   logic          nRST;
   logic [7:0]    SL_ADDR;
   logic [31:0]   SL_WDATA;
   logic [3:0]    SL_BE;
   logic [3:0]    SL_RD;
   logic [3:0]    SL_WR;
   logic [127:0]  SL_RDATA;
   logic [3:0]    SL_ACK;
   logic          ERR;
   logic [31:0]   ERR_ADDR;

   int tests = 0;
   int fails = 0;
   int n;

   mcs_io_bus_ctrl_if bus();

   mcs_io_bus_ctrl dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .io       (bus),
      .SL_ADDR  (SL_ADDR),
      .SL_WDATA (SL_WDATA),
      .SL_BE    (SL_BE),
      .SL_RD    (SL_RD),
      .SL_WR    (SL_WR),
      .SL_RDATA (SL_RDATA),
      .SL_ACK   (SL_ACK),
      .ERR      (ERR),
      .ERR_ADDR (ERR_ADDR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Presents one MCS request for a single edge; returns in the cycle after capture.
   task automatic mcs_req(input logic [31:0] addr, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [31:0] wdata);
      bus.IO_Address      = addr;
      bus.IO_Addr_Strobe  = 1'b1;
      bus.IO_Read_Strobe  = rd;
      bus.IO_Write_Strobe = wr;
      bus.IO_Byte_Enable  = be;
      bus.IO_Write_Data   = wdata;
      step();
      bus.IO_Addr_Strobe  = 1'b0;
      bus.IO_Read_Strobe  = 1'b0;
      bus.IO_Write_Strobe = 1'b0;
   endtask

   task automatic wait_ready(input int max_cyc, output int cyc);
      cyc = 0;
      while (bus.IO_Ready !== 1'b1 && cyc < max_cyc) begin
         step();
         cyc++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST                = 1'b1;
      bus.IO_Address      = '0;
      bus.IO_Addr_Strobe  = 1'b0;
      bus.IO_Read_Strobe  = 1'b0;
      bus.IO_Write_Strobe = 1'b0;
      bus.IO_Byte_Enable  = '0;
      bus.IO_Write_Data   = '0;
      SL_RDATA            = '0;
      SL_ACK              = '0;
      #1 nRST = 1'b0;
      #2;
      chk("rst_ready",    {31'd0, bus.IO_Ready}, 32'd0);
      chk("rst_rdata",    bus.IO_Read_Data, 32'd0);
      chk("rst_err",      {31'd0, ERR}, 32'd0);
      chk("rst_err_addr", ERR_ADDR, 32'd0);
      chk("rst_sl_rd",    {28'd0, SL_RD}, 32'd0);
      chk("rst_sl_wr",    {28'd0, SL_WR}, 32'd0);
      step();
      nRST = 1'b1;
      step();

      // Read slave 1, ACK in ISSUE.
      SL_RDATA[63:32] = 32'h1234_5678;
      mcs_req(32'hC000_0104, 1'b1, 1'b0, 4'hF, 32'h0);
      chk("rd_sl_rd",   {28'd0, SL_RD}, 32'h2);
      chk("rd_sl_addr", {24'd0, SL_ADDR}, 32'h04);
      chk("rd_ready_k1", {31'd0, bus.IO_Ready}, 32'd0);
      SL_ACK = 4'b0010;
      step();
      SL_ACK = 4'b0000;
      chk("rd_ready_k2", {31'd0, bus.IO_Ready}, 32'd1);
      chk("rd_data",     bus.IO_Read_Data, 32'h1234_5678);
      chk("rd_err",      {31'd0, ERR}, 32'd0);
      chk("rd_sl_rd_off", {28'd0, SL_RD}, 32'd0);
      step();
      chk("rd_ready_off", {31'd0, bus.IO_Ready}, 32'd0);
      chk("rd_data_hold", bus.IO_Read_Data, 32'h1234_5678);
      $display("[TB] read slave1 done");

      // Write slave 3, ACK 5 cycles after SL_WR.
      mcs_req(32'hC000_0300, 1'b0, 1'b1, 4'b0001, 32'h0000_00A5);
      chk("wr_sl_wr",   {28'd0, SL_WR}, 32'h8);
      chk("wr_sl_wdata", SL_WDATA, 32'h0000_00A5);
      chk("wr_sl_be",   {28'd0, SL_BE}, 32'h1);
      chk("wr_sl_addr", {24'd0, SL_ADDR}, 32'h00);
      for (int i = 0; i < 4; i++) step();
      chk("wr_ready_k5", {31'd0, bus.IO_Ready}, 32'd0);
      chk("wr_sl_wr_off", {28'd0, SL_WR}, 32'd0);
      step();
      SL_ACK = 4'b1000;
      step();
      SL_ACK = 4'b0000;
      chk("wr_ready_k7", {31'd0, bus.IO_Ready}, 32'd1);
      chk("wr_rdata_kept", bus.IO_Read_Data, 32'h1234_5678);
      step();
      $display("[TB] write slave3 done");

      // Unmapped read.
      mcs_req(32'h8000_0000, 1'b1, 1'b0, 4'hF, 32'h0);
      chk("um_sl_rd",    {28'd0, SL_RD}, 32'd0);
      chk("um_ready",    {31'd0, bus.IO_Ready}, 32'd1);
      chk("um_err",      {31'd0, ERR}, 32'd1);
      chk("um_err_addr", ERR_ADDR, 32'h8000_0000);
      chk("um_data",     bus.IO_Read_Data, 32'hFFFF_FFFF);
      step();
      chk("um_ready_off", {31'd0, bus.IO_Ready}, 32'd0);
      chk("um_err_off",   {31'd0, ERR}, 32'd0);
      $display("[TB] unmapped read done");

      // Silent slave 2: timeout.
      SL_RDATA[95:64] = 32'hDEAD_0002;
      mcs_req(32'hC000_0200, 1'b1, 1'b0, 4'hF, 32'h0);
      wait_ready(400, n);
      chk("to_latency",  n + 1, 32'd257);
      chk("to_err",      {31'd0, ERR}, 32'd1);
      chk("to_err_addr", ERR_ADDR, 32'hC000_0200);
      chk("to_data",     bus.IO_Read_Data, 32'hFFFF_FFFF);
      step();
      chk("to_err_off",  {31'd0, ERR}, 32'd0);
      $display("[TB] timeout read done");

      // ACK on exactly the TIMEOUT cycle wins.
      SL_RDATA[31:0] = 32'hCAFE_0001;
      mcs_req(32'hC000_0008, 1'b1, 1'b0, 4'hF, 32'h0);
      for (int i = 0; i < 255; i++) step();
      chk("ackto_ready_pre", {31'd0, bus.IO_Ready}, 32'd0);
      SL_ACK = 4'b0001;
      step();
      SL_ACK = 4'b0000;
      chk("ackto_ready", {31'd0, bus.IO_Ready}, 32'd1);
      chk("ackto_err",   {31'd0, ERR}, 32'd0);
      chk("ackto_data",  bus.IO_Read_Data, 32'hCAFE_0001);
      chk("ackto_err_addr_sticky", ERR_ADDR, 32'hC000_0200);
      step();
      $display("[TB] ack at timeout done");

      // Read+write together to slave 2, wrong-slave ACK, ignored strobe while busy.
      mcs_req(32'hC000_0210, 1'b1, 1'b1, 4'hF, 32'h1122_3344);
      chk("rw_sl_wr", {28'd0, SL_WR}, 32'h4);
      chk("rw_sl_rd", {28'd0, SL_RD}, 32'd0);
      SL_ACK = 4'b0010;
      step();
      chk("rw_wrong_ack_k2", {31'd0, bus.IO_Ready}, 32'd0);
      mcs_req(32'hC000_0104, 1'b1, 1'b0, 4'hF, 32'h0);
      chk("rw_wrong_ack_k3", {31'd0, bus.IO_Ready}, 32'd0);
      chk("rw_busy_no_rd",   {28'd0, SL_RD}, 32'd0);
      chk("rw_addr_held",    {24'd0, SL_ADDR}, 32'h10);
      SL_ACK = 4'b0100;
      step();
      SL_ACK = 4'b0000;
      chk("rw_ready",     {31'd0, bus.IO_Ready}, 32'd1);
      chk("rw_data_kept", bus.IO_Read_Data, 32'hCAFE_0001);
      step();
      chk("rw_no_queue_ready", {31'd0, bus.IO_Ready}, 32'd0);
      chk("rw_no_queue_rd",    {28'd0, SL_RD}, 32'd0);
      $display("[TB] read+write and wrong ack done");

      // Reset while waiting on slave 1.
      mcs_req(32'hC000_0104, 1'b1, 1'b0, 4'hF, 32'h0);
      step();
      step();
      #1 nRST = 1'b0;
      #1;
      chk("rstw_ready",    {31'd0, bus.IO_Ready}, 32'd0);
      chk("rstw_rdata",    bus.IO_Read_Data, 32'd0);
      chk("rstw_err_addr", ERR_ADDR, 32'd0);
      chk("rstw_sl_addr",  {24'd0, SL_ADDR}, 32'd0);
      step();
      chk("rstw_ready_held", {31'd0, bus.IO_Ready}, 32'd0);
      nRST = 1'b1;
      step();
      mcs_req(32'hC000_0104, 1'b1, 1'b0, 4'hF, 32'h0);
      chk("rstw_new_sl_rd", {28'd0, SL_RD}, 32'h2);
      SL_ACK = 4'b0010;
      step();
      SL_ACK = 4'b0000;
      chk("rstw_new_ready", {31'd0, bus.IO_Ready}, 32'd1);
      chk("rstw_new_data",  bus.IO_Read_Data, 32'h1234_5678);
      step();
      $display("[TB] reset during wait done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
